conv_pass_sequencer: RTL

- Top-level sequencer for one convolution layer on the PE array.
- Latches the requested OP_MODE, drives change_mode and conv_continue to the zero-psum generator and PE array, and steps OP_STAGE through weight load, ifmap load and CONV.
- Counts accepted psums to detect end of each ofmap pass and repeats for a configured number of passes per mode.
- Sits between the layer-level host/DMA control and the array-level datapath.

---
 rtl/conv_pass_sequencer_pkg.sv | 30 +++
 rtl/conv_pass_sequencer_psum_pass_counter.sv | 41 ++++
 rtl/conv_pass_sequencer.sv | 124 ++++++++++++
 3 files changed

// File: rtl/conv_pass_sequencer_pkg.sv
// Shared types and size constants for the convolution layer sequencer and the
// zero-psum generator, so both sides agree on ofmap sizes and stage encoding.
package conv_pass_sequencer_pkg;

    typedef enum logic [2:0] {
        MODE1 = 3'd0,
        MODE2 = 3'd1,
        MODE3 = 3'd2,
        MODE4 = 3'd3,
        MODE5 = 3'd4,
        MODE6 = 3'd5,
        MODE7 = 3'd6,
        MODE8 = 3'd7
    } op_mode_t;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WLOAD = 3'd1,
        ILOAD = 3'd2,
        CONV  = 3'd3,
        DONE  = 3'd4
    } op_stage_t;

    localparam int DEF_L1_OFMAP = 55;
    localparam int DEF_L2_OFMAP = 27;
    localparam int DEF_L3_OFMAP = 13;
    localparam int DEF_FILTERS  = 4;
    localparam int DEF_PASS_W   = 6;

endpackage

// File: rtl/conv_pass_sequencer_psum_pass_counter.sv
// Counts accepted psums within one ofmap pass and flags the ack that completes
// the pass; the target depends on the latched layer mode.
module psum_pass_counter
    import conv_pass_sequencer_pkg::*;
#(
    parameter int L1_OFMAP = DEF_L1_OFMAP,
    parameter int L2_OFMAP = DEF_L2_OFMAP,
    parameter int L3_OFMAP = DEF_L3_OFMAP,
    parameter int FILTERS  = DEF_FILTERS,
    parameter int CNT_W    = 9
) (
    input  logic     clk,
    input  logic     clr,
    input  logic     ack,
    input  op_mode_t mode,
    output logic     last_ack
);

    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] target;

    always_comb begin
        target = CNT_W'(L3_OFMAP * FILTERS);
        case (mode)
            MODE1, MODE2: target = CNT_W'(L1_OFMAP * FILTERS);
            MODE3:        target = CNT_W'(L2_OFMAP * FILTERS);
            default:      target = CNT_W'(L3_OFMAP * FILTERS);
        endcase
    end

    assign last_ack = ack && (count == target - CNT_W'(1));

    // Holds on the final ack; the sequencer leaves CONV next edge, which clears it.
    always_ff @(posedge clk) begin
        if (clr)
            count <= '0;
        else if (ack && !last_ack)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/conv_pass_sequencer.sv
// Layer-level sequencer: latches the layer mode, steps WLOAD -> ILOAD -> CONV per
// pass, and pulses change_mode / conv_continue / layer_done toward the PE array.
module conv_pass_sequencer
    import conv_pass_sequencer_pkg::*;
#(
    parameter int L1_OFMAP = DEF_L1_OFMAP,
    parameter int L2_OFMAP = DEF_L2_OFMAP,
    parameter int L3_OFMAP = DEF_L3_OFMAP,
    parameter int FILTERS  = DEF_FILTERS,
    parameter int PASS_W   = DEF_PASS_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  op_mode_t          mode_in,
    input  logic [PASS_W-1:0] num_pass,
    input  logic              wload_done,
    input  logic              iload_done,
    input  logic              psum_ack,
    input  logic              abort,
    output logic              change_mode,
    output op_mode_t          mode_out,
    output logic              conv_continue,
    output op_stage_t         op_stage,
    output logic [PASS_W-1:0] pass_idx,
    output logic              busy,
    output logic              layer_done
);

    localparam int MAX_OFMAP = (L1_OFMAP > L2_OFMAP)
                             ? ((L1_OFMAP > L3_OFMAP) ? L1_OFMAP : L3_OFMAP)
                             : ((L2_OFMAP > L3_OFMAP) ? L2_OFMAP : L3_OFMAP);
    localparam int CNT_W = $clog2(MAX_OFMAP * FILTERS) + 1;

    logic [PASS_W-1:0] num_pass_q;
    logic              last_ack;
    logic              cnt_clr;

    // Counter only runs in CONV, so acks in any other stage never count.
    assign cnt_clr = rst || abort || (op_stage != CONV);

    psum_pass_counter #(
        .L1_OFMAP (L1_OFMAP),
        .L2_OFMAP (L2_OFMAP),
        .L3_OFMAP (L3_OFMAP),
        .FILTERS  (FILTERS),
        .CNT_W    (CNT_W)
    ) u_psum_pass_counter (
        .clk      (clk),
        .clr      (cnt_clr),
        .ack      (psum_ack),
        .mode     (mode_out),
        .last_ack (last_ack)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            op_stage      <= IDLE;
            mode_out      <= MODE1;
            pass_idx      <= '0;
            num_pass_q    <= '0;
            change_mode   <= 1'b0;
            conv_continue <= 1'b0;
            layer_done    <= 1'b0;
            busy          <= 1'b0;
        end else if (abort) begin
            op_stage      <= IDLE;
            pass_idx      <= '0;
            num_pass_q    <= '0;
            change_mode   <= 1'b0;
            conv_continue <= 1'b0;
            layer_done    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            change_mode   <= 1'b0;
            conv_continue <= 1'b0;
            layer_done    <= 1'b0;
            case (op_stage)
                IDLE: begin
                    if (start) begin
                        op_stage    <= WLOAD;
                        mode_out    <= mode_in;
                        change_mode <= 1'b1;
                        pass_idx    <= '0;
                        num_pass_q  <= (num_pass == '0) ? PASS_W'(1) : num_pass;
                        busy        <= 1'b1;
                    end
                end
                WLOAD: begin
                    if (wload_done)
                        op_stage <= ILOAD;
                end
                ILOAD: begin
                    // Pass 0 was already announced by change_mode.
                    if (iload_done) begin
                        op_stage      <= CONV;
                        conv_continue <= (pass_idx != '0);
                    end
                end
                CONV: begin
                    if (last_ack) begin
                        if (pass_idx == num_pass_q - PASS_W'(1)) begin
                            op_stage   <= DONE;
                            layer_done <= 1'b1;
                        end else begin
                            // Weights stay resident; only the next ifmap tile is loaded.
                            op_stage <= ILOAD;
                            pass_idx <= pass_idx + PASS_W'(1);
                        end
                    end
                end
                DONE: begin
                    op_stage <= IDLE;
                    busy     <= 1'b0;
                end
                default: begin
                    op_stage <= IDLE;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
